servo_move_scheduler: RTL and testbench

- Sits between the seven-segment decoders and the per-segment servo drivers.
- Receives the desired segment pattern and releases bit changes to the servo `control_input` lines.
- At most MAX_ACTIVE servos may be moving at any time, which bounds supply inrush when many segments flip together (e.g. 19:59 -> 20:00).
- Grants are round-robin with a per-servo settle timer. The block is gated by the `main_program` presence signal.

---
 rtl/servo_sched_pkg.sv | 17 +
 rtl/servo_move_scheduler_rr_pick.sv | 35 +++
 rtl/servo_move_scheduler.sv | 120 ++++++++++++
 tb/tb_servo_move_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_sched_pkg.sv
// Shared constants and slot record for the servo move scheduler.
// The slot record here is sized for the default 28-channel build.
package servo_sched_pkg;

    localparam int DEF_NUM_SERVOS    = 28;
    localparam int DEF_MAX_ACTIVE    = 4;
    localparam int DEF_SETTLE_CYCLES = 15_000_000;
    localparam int DEF_CNT_W         = 24;
    localparam int DEF_IDX_W         = $clog2(DEF_NUM_SERVOS);

    typedef struct packed {
        logic                 busy;
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_CNT_W-1:0] cnt;
    } slot_t;

endpackage

// File: rtl/servo_move_scheduler_rr_pick.sv
// Round-robin picker: rotates the request vector to start at ptr, finds the first set bit,
// and maps the result back to an absolute index.
module rr_pick #(
    parameter int N     = 28,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] rotated;
    int           offset;
    int           sum;

    always_comb begin
        rotated = '0;
        offset  = 0;
        sum     = 0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            rotated[k] = req[IDX_W'(sum)];
        end
        found = |rotated;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) offset = k;
        end
        sum = int'(ptr) + offset;
        if (sum >= N) sum = sum - N;
        idx = IDX_W'(sum);
    end

endmodule

// File: rtl/servo_move_scheduler.sv
// Releases segment-pattern changes to the servo pins, keeping at most MAX_ACTIVE servos
// moving at once; grants are round-robin and each grant occupies a slot for SETTLE_CYCLES.
module servo_move_scheduler
    import servo_sched_pkg::*;
#(
    parameter int                    NUM_SERVOS    = DEF_NUM_SERVOS,
    parameter int                    MAX_ACTIVE    = DEF_MAX_ACTIVE,
    parameter int                    SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int                    CNT_W         = DEF_CNT_W,
    parameter logic [NUM_SERVOS-1:0] RESET_PATTERN = '1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              main_program,
    input  logic [NUM_SERVOS-1:0]             target,
    output logic [NUM_SERVOS-1:0]             applied,
    output logic [NUM_SERVOS-1:0]             in_motion,
    output logic                              grant_valid,
    output logic [$clog2(NUM_SERVOS)-1:0]     grant_idx,
    output logic [$clog2(MAX_ACTIVE+1)-1:0]   active_count,
    output logic                              busy
);

    localparam int IDX_W  = $clog2(NUM_SERVOS);
    localparam int ACT_W  = $clog2(MAX_ACTIVE + 1);
    localparam int SLOT_W = (MAX_ACTIVE > 1) ? $clog2(MAX_ACTIVE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SERVOS - 1);

    typedef struct packed {
        logic             busy;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } slot_rec_t;

    slot_rec_t             slots [MAX_ACTIVE];
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_SERVOS-1:0] pending;
    logic [NUM_SERVOS-1:0] eligible;
    logic [NUM_SERVOS-1:0] motion_clr;
    logic [NUM_SERVOS-1:0] grant_mask;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic                  free_found;
    logic [SLOT_W-1:0]     free_slot;
    logic                  do_grant;

    assign pending  = target ^ applied;
    assign eligible = pending & ~in_motion;

    rr_pick #(
        .N     (NUM_SERVOS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Free-slot search looks only at registered slot state, so a slot expiring on this
    // edge is reused one cycle later and the counter never feeds the arbiter directly.
    always_comb begin
        free_found   = 1'b0;
        free_slot    = '0;
        motion_clr   = '0;
        active_count = '0;
        for (int s = MAX_ACTIVE - 1; s >= 0; s--) begin
            if (!slots[s].busy) begin
                free_found = 1'b1;
                free_slot  = SLOT_W'(s);
            end
            if (slots[s].busy && slots[s].cnt == '0) motion_clr[slots[s].idx] = 1'b1;
            active_count = active_count + ACT_W'(slots[s].busy);
        end
    end

    assign do_grant = main_program & free_found & pick_found;

    always_comb begin
        grant_mask = '0;
        if (do_grant) grant_mask[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < MAX_ACTIVE; s++) begin
            if (reset) begin
                slots[s].busy <= 1'b0;
            end else if (do_grant && free_slot == SLOT_W'(s)) begin
                slots[s].busy <= 1'b1;
                slots[s].idx  <= pick_idx;
                slots[s].cnt  <= CNT_LOAD;
            end else if (slots[s].busy) begin
                if (slots[s].cnt == '0) slots[s].busy <= 1'b0;
                else                    slots[s].cnt  <= slots[s].cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            applied     <= RESET_PATTERN;
            in_motion   <= '0;
            rr_ptr      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            busy        <= 1'b0;
        end else begin
            grant_valid <= do_grant;
            busy        <= (|pending) | (|in_motion);
            in_motion   <= (in_motion & ~motion_clr) | grant_mask;
            if (do_grant) begin
                applied[pick_idx] <= target[pick_idx];
                grant_idx         <= pick_idx;
                rr_ptr            <= (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_servo_move_scheduler.sv
// Bench for servo_move_scheduler: table vectors, directed corner sequences and a random
// run, all checked against a per-servo remaining-time model.
module tb_servo_move_scheduler;

    localparam int N  = 8;
    localparam int MA = 2;
    localparam int S  = 10;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         main_program = 1'b0;
    logic [N-1:0] target = '1;
    logic [N-1:0] applied;
    logic [N-1:0] in_motion;
    logic         grant_valid;
    logic [2:0]   grant_idx;
    logic [1:0]   active_count;
    logic         busy;

    always #5 clk = ~clk;

    servo_move_scheduler #(
        .NUM_SERVOS    (N),
        .MAX_ACTIVE    (MA),
        .SETTLE_CYCLES (S),
        .CNT_W         (CW),
        .RESET_PATTERN (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .main_program (main_program),
        .target       (target),
        .applied      (applied),
        .in_motion    (in_motion),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .active_count (active_count),
        .busy         (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: each servo has a remaining-motion time; slots are implied by how many are nonzero.
    logic [N-1:0] m_applied;
    int           m_rem [N];
    int           m_rr;
    logic         m_gv;
    int           m_gi;
    logic         m_busy;
    int           gcyc [N];
    int           gcount [N];

    function automatic logic [N-1:0] m_motion();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_rem[i] > 0);
        return v;
    endfunction

    function automatic int m_active();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_rem[i] > 0) c++;
        return c;
    endfunction

    task automatic model_edge(input logic r, input logic mp, input logic [N-1:0] t);
        logic [N-1:0] pend;
        logic [N-1:0] mot;
        logic [N-1:0] elig;
        int g;
        if (r) begin
            m_applied = '1;
            for (int i = 0; i < N; i++) m_rem[i] = 0;
            m_rr   = 0;
            m_gv   = 1'b0;
            m_gi   = 0;
            m_busy = 1'b0;
        end else begin
            pend = t ^ m_applied;
            mot  = m_motion();
            elig = pend & ~mot;
            g = -1;
            if (mp && m_active() < MA) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && elig[(m_rr + k) % N]) g = (m_rr + k) % N;
                end
            end
            m_busy = (pend != 0) || (mot != 0);
            for (int i = 0; i < N; i++) if (m_rem[i] > 0) m_rem[i]--;
            m_gv = (g >= 0);
            if (g >= 0) begin
                m_applied[g] = t[g];
                m_rem[g]     = S;
                m_rr         = (g + 1) % N;
                m_gi         = g;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic mp, input logic [N-1:0] t);
        reset        = r;
        main_program = mp;
        target       = t;
        @(posedge clk);
        model_edge(r, mp, t);
        @(negedge clk);
        cyc++;
        if (grant_valid) begin
            gcyc[grant_idx] = cyc;
            gcount[grant_idx]++;
        end
        check("model_state", {applied, in_motion, active_count, busy, grant_valid},
              {m_applied, m_motion(), 2'(m_active()), m_busy, m_gv});
        if (m_gv) check("model_grant_idx", 32'(grant_idx), 32'(m_gi));
    endtask

    task automatic wait_idle(input logic [N-1:0] t, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && active_count == 0 && in_motion == 0) break;
            step(1'b0, 1'b1, t);
        end
        check("reach_idle", {busy, active_count, in_motion}, 32'd0);
    endtask

    typedef struct {
        logic       r;
        logic       mp;
        logic [7:0] t;
        logic [7:0] e_app;
        logic       e_gv;
        logic [2:0] e_gi;
        logic [1:0] e_act;
        logic       e_busy;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int c0, done, maxact, c3, n3, z;
        logic [N-1:0] hi, tv, seen;
        logic tog;

        for (int i = 0; i < N; i++) begin
            gcyc[i] = -1;
            gcount[i] = 0;
            m_rem[i] = 0;
        end

        // Reset and a long idle stretch with the target equal to the reset pattern.
        step(1'b1, 1'b1, 8'hFF);
        check("reset_state", {applied, in_motion, active_count, grant_valid, busy},
              {8'hFF, 8'h00, 2'd0, 1'b0, 1'b0});
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, 8'hFF);
            check("idle_no_grant", {grant_valid, busy, applied}, {1'b0, 1'b0, 8'hFF});
        end

        tbl[0] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 8'hFE, 1'b1, 3'd0, 2'd1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'hFC, 1'b1, 3'd1, 2'd2, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hFC, 1'b0, 3'd0, 2'd2, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 8'hFC, 1'b0, 3'd0, 2'd2, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].r, tbl[i].mp, tbl[i].t);
            check("tbl_outputs", {applied, grant_valid, active_count, busy},
                  {tbl[i].e_app, tbl[i].e_gv, tbl[i].e_act, tbl[i].e_busy});
            if (tbl[i].e_gv) check("tbl_grant_idx", 32'(grant_idx), 32'(tbl[i].e_gi));
        end

        // Flip all segments: slots limit concurrency, idx2 follows idx0's slot release.
        c0 = gcyc[0];
        done = -1;
        maxact = active_count;
        for (int i = 0; i < 60; i++) begin
            if (applied == 8'h00 && active_count == 0) break;
            step(1'b0, 1'b1, 8'h00);
            if (active_count > maxact) maxact = active_count;
            if (applied == 8'h00 && done < 0) done = cyc;
        end
        check("flip_idle", {applied, active_count}, 32'd0);
        check("idx2_after_idx0", 32'(gcyc[2] - c0), 32'(S + 1));
        check("all_applied_in_time", 32'(done >= 0 && done - c0 <= 4 * S + 4), 32'd1);
        check("max_active_bound", 32'(maxact <= MA), 32'd1);

        // Gated: no grants, applied holds, busy reports; then grants resume at the pointer.
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 8'h0F);
            check("gated_hold", {grant_valid, applied}, {1'b0, 8'h00});
        end
        check("gated_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h0F);
            if (grant_valid) break;
        end
        check("resume_grant", {grant_valid, grant_idx}, {1'b1, 3'd0});

        // Target wiggle on a moving servo: exactly one re-grant, only after its timer.
        c3 = -1;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 8'h0F);
            if (grant_valid && grant_idx == 3'd3) begin
                c3 = cyc;
                break;
            end
        end
        check("idx3_granted", 32'(c3 >= 0), 32'd1);
        n3 = gcount[3];
        step(1'b0, 1'b1, 8'h07);
        step(1'b0, 1'b1, 8'h0F);
        step(1'b0, 1'b1, 8'h07);
        wait_idle(8'h07, 80);
        check("idx3_regrant_count", 32'(gcount[3] - n3), 32'd1);
        check("idx3_regrant_gap", 32'(gcyc[3] - c3), 32'(S + 1));

        // Fairness: idx0 flickers every cycle, 1..7 stay pending.
        hi = ~applied;
        tog = applied[0];
        seen = '0;
        z = 0;
        for (int i = 0; i < 200; i++) begin
            if (seen == 8'hFE) break;
            tog = ~tog;
            step(1'b0, 1'b1, {hi[7:1], tog});
            if (grant_valid) begin
                if (grant_idx == 3'd0) begin
                    z++;
                    if (z == 2) check("fair_before_second_idx0", 32'(seen), 32'hFE);
                end else begin
                    seen[grant_idx] = 1'b1;
                end
            end
        end
        check("fair_all_granted", 32'(seen), 32'hFE);
        wait_idle({hi[7:1], 1'b0}, 80);

        // Reset in the middle of motion with both slots occupied.
        tv = ~applied;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, tv);
            if (active_count == 2) break;
        end
        check("two_active", 32'(active_count), 32'd2);
        step(1'b1, 1'b1, tv);
        check("mid_reset", {applied, in_motion, active_count, grant_valid, busy},
              {8'hFF, 8'h00, 2'd0, 1'b0, 1'b0});
        step(1'b0, 1'b1, 8'hA5);
        check("ptr_reset_first_grant", {grant_valid, grant_idx}, {1'b1, 3'd1});

        // Random traffic against the model.
        tv = 8'hA5;
        for (int i = 0; i < 400; i++) begin
            logic r, mp;
            r  = ($urandom_range(0, 63) == 0);
            mp = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) tv = tv ^ 8'($urandom);
            step(r, mp, tv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
